// File: rtl/switch_box_ctx_config.sv
// Multi-context configuration store for the CLB switch box: scan-chain staging register,
// NCTX committed planes and a break-before-make context switcher driving conf_out.
module switch_box_ctx_config #(
    parameter int WS           = 8,
    parameter int WD           = 8,
    parameter int NCTX         = 2,
    parameter int BLANK_CYCLES = 2,
    localparam int CONF_W      = (WS + WD / 2) * 6,
    localparam int CW          = (NCTX > 1) ? $clog2(NCTX) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              shift_in,
    output logic              shift_out,
    input  logic              set_in,
    input  logic [CW-1:0]     ctx_wr_sel,
    input  logic [CW-1:0]     ctx_sel,
    input  logic              ctx_switch_req,
    output logic              ctx_switch_ack,
    output logic [CW-1:0]     ctx_active,
    output logic              load_err,
    output logic [CONF_W-1:0] conf_out
);

    localparam int NPL   = 1 << CW;
    localparam int CNT_W = $clog2(CONF_W + 1);
    localparam int BC_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BC_W-1:0]  BLANK_LOAD = BC_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(CONF_W);

    // Bit i set when plane index i exists; keeps range checks free of width-limited compares.
    function automatic logic [NPL-1:0] ctx_ok_mask();
        logic [NPL-1:0] m;
        for (int i = 0; i < NPL; i++) m[i] = (i < NCTX);
        return m;
    endfunction

    localparam logic [NPL-1:0] CTX_OK = ctx_ok_mask();

    typedef enum logic [1:0] {IDLE, BLANK, MAKE} state_t;

    state_t            state, state_nxt;
    logic [BC_W-1:0]   bcnt, bcnt_nxt;
    logic [CW-1:0]     tgt, tgt_nxt;
    logic [CW-1:0]     act_nxt;
    logic              ack_nxt;

    logic [CONF_W-1:0] sr;
    logic [CNT_W-1:0]  cnt;
    logic [CONF_W-1:0] plane [NPL];

    assign shift_out = sr[CONF_W-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            bcnt           <= '0;
            tgt            <= '0;
            ctx_active     <= '0;
            ctx_switch_ack <= 1'b0;
        end else begin
            state          <= state_nxt;
            bcnt           <= bcnt_nxt;
            tgt            <= tgt_nxt;
            ctx_active     <= act_nxt;
            ctx_switch_ack <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        tgt_nxt   = tgt;
        act_nxt   = ctx_active;
        ack_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (ctx_switch_req && CTX_OK[ctx_sel]) begin
                    if (ctx_sel == ctx_active) begin
                        ack_nxt = 1'b1;
                    end else begin
                        state_nxt = BLANK;
                        bcnt_nxt  = BLANK_LOAD;
                        tgt_nxt   = ctx_sel;
                    end
                end
            end
            BLANK: begin
                if (bcnt == '0) begin
                    state_nxt = MAKE;
                    act_nxt   = tgt;
                end else begin
                    bcnt_nxt = bcnt - 1'b1;
                end
            end
            MAKE: begin
                state_nxt = IDLE;
                ack_nxt   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Commit samples the pre-edge staging word, so a same-cycle shift never corrupts it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sr       <= '0;
            cnt      <= '0;
            load_err <= 1'b0;
            conf_out <= '0;
            for (int i = 0; i < NPL; i++) plane[i] <= '0;
        end else begin
            if (cen) sr <= {sr[CONF_W-2:0], shift_in};
            if (set_in) begin
                if (cnt == CNT_FULL && CTX_OK[ctx_wr_sel]) begin
                    plane[ctx_wr_sel] <= sr;
                    load_err          <= 1'b0;
                end else begin
                    load_err <= 1'b1;
                end
                cnt <= cen ? CNT_W'(1) : '0;
            end else if (cen && cnt != CNT_FULL) begin
                cnt <= cnt + 1'b1;
            end
            conf_out <= (state == BLANK) ? '0 : plane[ctx_active];
        end
    end

endmodule

// File: tb/tb_switch_box_ctx_config.sv
// Directed bench for switch_box_ctx_config: scan load/commit, short-load error,
// break-before-make context switching and reset during a switch.
module tb_switch_box_ctx_config;

    localparam int CONF_W = 72;

    logic              clk = 1'b0;
    logic              rst;
    logic              cen;
    logic              shift_in;
    logic              shift_out;
    logic              set_in;
    logic              ctx_wr_sel;
    logic              ctx_sel;
    logic              ctx_switch_req;
    logic              ctx_switch_ack;
    logic              ctx_active;
    logic              load_err;
    logic [CONF_W-1:0] conf_out;

    int n_chk  = 0;
    int n_fail = 0;

    logic [CONF_W-1:0] pat_a;
    logic [CONF_W-1:0] ones;
    logic [CONF_W-1:0] zero;
    logic [CONF_W-1:0] got;

    switch_box_ctx_config #(
        .WS(8), .WD(8), .NCTX(2), .BLANK_CYCLES(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cen            (cen),
        .shift_in       (shift_in),
        .shift_out      (shift_out),
        .set_in         (set_in),
        .ctx_wr_sel     (ctx_wr_sel),
        .ctx_sel        (ctx_sel),
        .ctx_switch_req (ctx_switch_req),
        .ctx_switch_ack (ctx_switch_ack),
        .ctx_active     (ctx_active),
        .load_err       (load_err),
        .conf_out       (conf_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [CONF_W-1:0] obs, input logic [CONF_W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [CONF_W-1:0] w);
        for (int i = CONF_W - 1; i >= 0; i--) begin
            cen      = 1'b1;
            shift_in = w[i];
            step();
        end
        cen      = 1'b0;
        shift_in = 1'b0;
    endtask

    initial begin
        pat_a = {9{8'hA5}};
        ones  = '1;
        zero  = '0;
        got   = '0;
        rst = 1'b0; cen = 1'b0; shift_in = 1'b0; set_in = 1'b0;
        ctx_wr_sel = 1'b0; ctx_sel = 1'b0; ctx_switch_req = 1'b0;

        // 1. reset
        step(); step();
        rst = 1'b1;
        step();
        chk ("rst_conf_out",  conf_out,       zero);
        chk1("rst_ctx_active", ctx_active,    1'b0);
        chk1("rst_load_err",  load_err,       1'b0);
        chk1("rst_shift_out", shift_out,      1'b0);
        chk1("rst_ack",       ctx_switch_ack, 1'b0);

        // 2. full load and commit to plane 0
        load(pat_a);
        chk1("sr_msb_out", shift_out, 1'b1);
        set_in = 1'b1; ctx_wr_sel = 1'b0;
        step();
        set_in = 1'b0;
        chk ("commit_lat1", conf_out, zero);
        step();
        chk ("commit_lat2", conf_out, pat_a);
        chk1("commit_err", load_err, 1'b0);
        for (int i = 0; i < CONF_W; i++) begin
            got[CONF_W-1-i] = shift_out;
            cen = 1'b1; shift_in = 1'b0;
            step();
        end
        cen = 1'b0;
        chk ("chain_replay", got, pat_a);

        // 3. short load rejected, full load accepted
        set_in = 1'b1; ctx_wr_sel = 1'b1;
        step();
        set_in = 1'b0;
        chk1("clear_cnt_set_err", load_err, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cen = 1'b1; shift_in = 1'b1;
            step();
        end
        cen = 1'b0;
        set_in = 1'b1; ctx_wr_sel = 1'b0;
        step();
        set_in = 1'b0;
        chk1("short_load_err", load_err, 1'b1);
        step();
        chk ("short_plane0_kept", conf_out, pat_a);
        load(ones);
        set_in = 1'b1; ctx_wr_sel = 1'b1;
        step();
        set_in = 1'b0;
        chk1("full_load_err_clr", load_err, 1'b0);
        step();
        chk ("plane1_not_active", conf_out, pat_a);

        // 4. switch to plane 1 with blanking
        ctx_sel = 1'b1; ctx_switch_req = 1'b1;
        step();
        ctx_switch_req = 1'b0;
        chk ("sw_e0_conf", conf_out, pat_a);
        chk1("sw_e0_ack", ctx_switch_ack, 1'b0);
        step();
        chk ("sw_blank1", conf_out, zero);
        chk1("sw_blank1_ack", ctx_switch_ack, 1'b0);
        ctx_sel = 1'b0; ctx_switch_req = 1'b1;
        step();
        ctx_switch_req = 1'b0; ctx_sel = 1'b1;
        chk ("sw_blank2", conf_out, zero);
        chk1("sw_blank2_act", ctx_active, 1'b1);
        chk1("sw_blank2_ack", ctx_switch_ack, 1'b0);
        step();
        chk ("sw_make_conf", conf_out, ones);
        chk1("sw_make_ack", ctx_switch_ack, 1'b1);
        step();
        chk1("sw_ack_pulse", ctx_switch_ack, 1'b0);
        step(); step(); step();
        chk ("sw_drop_conf", conf_out, ones);
        chk1("sw_drop_act", ctx_active, 1'b1);
        chk1("sw_drop_ack", ctx_switch_ack, 1'b0);

        // 5. request for the already-active plane
        ctx_sel = 1'b1; ctx_switch_req = 1'b1;
        step();
        ctx_switch_req = 1'b0;
        chk1("same_ack", ctx_switch_ack, 1'b1);
        chk ("same_conf0", conf_out, ones);
        step();
        chk1("same_ack_end", ctx_switch_ack, 1'b0);
        chk ("same_conf1", conf_out, ones);

        // 6. reset during BLANK
        ctx_sel = 1'b0; ctx_switch_req = 1'b1;
        step();
        ctx_switch_req = 1'b0;
        step();
        chk ("rb_blank", conf_out, zero);
        rst = 1'b0;
        step();
        chk ("rb_conf", conf_out, zero);
        chk1("rb_act", ctx_active, 1'b0);
        chk1("rb_ack", ctx_switch_ack, 1'b0);
        chk1("rb_err", load_err, 1'b0);
        chk1("rb_sout", shift_out, 1'b0);
        rst = 1'b1;
        step(); step();
        chk1("rb_post_ack", ctx_switch_ack, 1'b0);
        chk ("rb_post_conf", conf_out, zero);
        ctx_sel = 1'b0; ctx_switch_req = 1'b1;
        step();
        ctx_switch_req = 1'b0;
        chk1("rb_idle_ack", ctx_switch_ack, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
